// File: rtl/vic_sound_pkg.sv
// Shared constants and helpers for the VIC sound generator: LFSR definition,
// voice-register field layout and register-window decode.
package vic_sound_pkg;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  // Taps 16,15,13,4 (1-based) -> bit indices 15,14,12,3
  localparam logic [15:0] LFSR_TAPS = 16'hD008;

  localparam int EN_BIT = 7;
  localparam int N_MSB  = 6;

  function automatic logic [3:0] reg_off(input logic [3:0] a, input logic [3:0] base);
    return a - base;
  endfunction

endpackage

// File: rtl/vic_sound_voice.sv
// One voice: register, 7-bit step counter with reload-on-127, and the voice bit.
// Noise instances take their new bit from the external LFSR instead of toggling.
module vic_sound_voice
  import vic_sound_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step_i,
  input  logic       wr_i,
  input  logic [7:0] din_i,
  input  logic       ext_i,
  input  logic       ext_bit_i,
  output logic [7:0] reg_o,
  output logic       bit_o,
  output logic       wrap_o
);

  logic [7:0]     reg_q, reg_d;
  logic [N_MSB:0] cnt_q, cnt_d;
  logic           bit_q, bit_d;
  logic           wrap;

  always_comb begin
    reg_d = wr_i ? din_i : reg_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    wrap  = 1'b0;
    // Disabled, or enabling this cycle: park at N with the bit low; overrides the step
    if (!reg_d[EN_BIT] || !reg_q[EN_BIT]) begin
      cnt_d = reg_d[N_MSB:0];
      bit_d = 1'b0;
    end else if (step_i) begin
      if (&cnt_q) begin
        cnt_d = reg_q[N_MSB:0];
        bit_d = ext_i ? ext_bit_i : ~bit_q;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q <= '0;
      cnt_q <= '0;
      bit_q <= 1'b0;
    end else begin
      reg_q <= reg_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
    end
  end

  assign reg_o  = reg_q;
  assign bit_o  = bit_q;
  // Only the noise instance reports wraps; they clock the LFSR
  assign wrap_o = wrap & ext_i;

endmodule

// File: rtl/vic_sound_gen.sv
// Parametrised VIC sound generator: NUM_TONE square-wave voices, one LFSR noise
// voice and a master volume behind a 16-entry CPU register window.
module vic_sound_gen
  import vic_sound_pkg::*;
#(
  parameter int         NUM_TONE = 3,
  parameter int         PRESCALE = 4,
  parameter logic [3:0] REG_BASE = 4'hA,
  parameter int         OUT_W    = $clog2((NUM_TONE+1)*15+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              we,
  input  logic [3:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [NUM_TONE:0] voice_on,
  output logic [OUT_W-1:0]  audio
);

  localparam int         PW      = PRESCALE + NUM_TONE - 1;
  localparam int         NV      = NUM_TONE + 1;
  localparam logic [3:0] VOL_OFF = 4'(NUM_TONE + 1);

  logic [PW-1:0]        pre_q, pre_d;
  logic [15:0]          lfsr_q, lfsr_d, lfsr_nx;
  logic [3:0]           vol_q, vol_d;
  logic [OUT_W-1:0]     audio_q, audio_d;
  logic [3:0]           off;
  logic [NUM_TONE:0][7:0] regs;
  logic [NUM_TONE:0]    wrap;
  logic                 noise_wrap;

  assign off        = reg_off(addr, REG_BASE);
  assign lfsr_nx    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign noise_wrap = |wrap;

  for (genvar g = 0; g < NV; g++) begin : g_voice
    // Voice g steps when the low PW-g prescaler bits are all ones; noise uses the tone 0 rate
    localparam int            RATE = (g == NUM_TONE) ? 0 : g;
    localparam logic [PW-1:0] MASK = PW'((64'd1 << (PW - RATE)) - 64'd1);
    logic step;
    assign step = ena && ((pre_q & MASK) == MASK);

    vic_sound_voice u_voice (
      .clk       (clk),
      .reset     (reset),
      .step_i    (step),
      .wr_i      (we && (off == 4'(g))),
      .din_i     (din),
      .ext_i     (g == NUM_TONE),
      .ext_bit_i (lfsr_nx[0]),
      .reg_o     (regs[g]),
      .bit_o     (voice_on[g]),
      .wrap_o    (wrap[g])
    );
  end

  always_comb begin
    pre_d   = ena ? pre_q + PW'(1) : pre_q;
    lfsr_d  = noise_wrap ? lfsr_nx : lfsr_q;
    vol_d   = (we && off == VOL_OFF) ? din[3:0] : vol_q;
    audio_d = OUT_W'($countones(voice_on) * int'(vol_q));
  end

  always_comb begin
    dout = '0;
    for (int k = 0; k < NV; k++)
      if (off == 4'(k)) dout = regs[k];
    if (off == VOL_OFF) dout = {4'h0, vol_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      vol_q   <= '0;
      audio_q <= '0;
    end else begin
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      vol_q   <= vol_d;
      audio_q <= audio_d;
    end
  end

  assign audio = audio_q;

endmodule
